// File: rtl/hp_access_arbiter.sv
// HP register owner for player and AI, with a round-robin arbitrated
// read-modify-write sequencer (IDLE -> CALC -> WRITE -> DONE) for attack/heal.
module hp_access_arbiter #(
  parameter int HP_W   = 8,
  parameter int MAX_HP = 100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_hp,
  input  logic [HP_W-1:0] p_init_hp,
  input  logic [HP_W-1:0] ai_init_hp,
  input  logic            p_req,
  input  logic            p_op,
  input  logic [HP_W-1:0] p_amt,
  input  logic            ai_req,
  input  logic            ai_op,
  input  logic [HP_W-1:0] ai_amt,
  output logic            p_gnt,
  output logic            ai_gnt,
  output logic            p_done,
  output logic            ai_done,
  output logic            busy,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            p_dead,
  output logic            ai_dead
);

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  localparam logic [HP_W:0] MAX_W = MAX_HP[HP_W:0];

  state_t          state_q;
  logic            last_ai_q;
  logic            p_gnt_q, ai_gnt_q, p_done_q, ai_done_q;
  logic [HP_W-1:0] p_hp_q, ai_hp_q;
  logic            op_q, tgt_ai_q;
  logic [HP_W-1:0] amt_q;
  logic [HP_W:0]   res_q;

  logic            start_d, pick_ai_d, sel_op_d, tgt_ai_d;
  logic [HP_W-1:0] sel_amt_d, tgt_hp_d;
  logic [HP_W:0]   calc_d;

  function automatic logic [HP_W:0] sat_sub(input logic [HP_W-1:0] hp,
                                            input logic [HP_W-1:0] amt);
    logic [HP_W-1:0] diff;
    diff = hp - amt;
    return (hp > amt) ? {1'b0, diff} : '0;
  endfunction

  function automatic logic [HP_W:0] sat_add(input logic [HP_W-1:0] hp,
                                            input logic [HP_W-1:0] amt);
    logic [HP_W:0] sum;
    sum = {1'b0, hp} + {1'b0, amt};
    return (sum > MAX_W) ? MAX_W : sum;
  endfunction

  // Selection: a tie goes to whoever did not win last time.
  always_comb begin
    start_d   = (p_req | ai_req) & ~p_dead & ~ai_dead;
    pick_ai_d = (p_req & ai_req) ? ~last_ai_q : ai_req;
    sel_op_d  = pick_ai_d ? ai_op  : p_op;
    sel_amt_d = pick_ai_d ? ai_amt : p_amt;
    // Heal hits the requester's own HP, attack hits the opponent's.
    tgt_ai_d  = pick_ai_d ? sel_op_d : ~sel_op_d;
    tgt_hp_d  = tgt_ai_q ? ai_hp_q : p_hp_q;
    calc_d    = op_q ? sat_add(tgt_hp_d, amt_q) : sat_sub(tgt_hp_d, amt_q);
  end

  // Operand latch and CALC result register
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      op_q     <= sel_op_d;
      amt_q    <= sel_amt_d;
      tgt_ai_q <= tgt_ai_d;
    end
    if (state_q == CALC) res_q <= calc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_ai_q <= 1'b1;
      p_gnt_q   <= 1'b0;
      ai_gnt_q  <= 1'b0;
      p_done_q  <= 1'b0;
      ai_done_q <= 1'b0;
      p_hp_q    <= '0;
      ai_hp_q   <= '0;
    end else if (load_hp) begin
      state_q   <= IDLE;
      p_gnt_q   <= 1'b0;
      ai_gnt_q  <= 1'b0;
      p_done_q  <= 1'b0;
      ai_done_q <= 1'b0;
      p_hp_q    <= p_init_hp;
      ai_hp_q   <= ai_init_hp;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q   <= CALC;
            p_gnt_q   <= ~pick_ai_d;
            ai_gnt_q  <= pick_ai_d;
            last_ai_q <= pick_ai_d;
          end
        end
        CALC: state_q <= WRITE;
        WRITE: begin
          if (tgt_ai_q) ai_hp_q <= res_q[HP_W-1:0];
          else          p_hp_q  <= res_q[HP_W-1:0];
          p_done_q  <= p_gnt_q;
          ai_done_q <= ai_gnt_q;
          state_q   <= DONE;
        end
        default: begin
          p_done_q  <= 1'b0;
          ai_done_q <= 1'b0;
          p_gnt_q   <= 1'b0;
          ai_gnt_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign p_gnt   = p_gnt_q;
  assign ai_gnt  = ai_gnt_q;
  assign p_done  = p_done_q;
  assign ai_done = ai_done_q;
  assign busy    = (state_q != IDLE);
  assign p_hp    = p_hp_q;
  assign ai_hp   = ai_hp_q;
  assign p_dead  = (p_hp_q == '0);
  assign ai_dead = (ai_hp_q == '0);

endmodule

// File: tb/tb_hp_access_arbiter.sv
// Bench for hp_access_arbiter: directed scenarios with literal expectations,
// then randomized requesters checked every cycle against a transaction model.
module tb_hp_access_arbiter;
  localparam int HP_W   = 8;
  localparam int MAX_HP = 100;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            load_hp = 1'b0;
  logic [HP_W-1:0] p_init_hp = '0, ai_init_hp = '0;
  logic            p_req = 1'b0, p_op = 1'b0, ai_req = 1'b0, ai_op = 1'b0;
  logic [HP_W-1:0] p_amt = '0, ai_amt = '0;
  logic            p_gnt, ai_gnt, p_done, ai_done, busy, p_dead, ai_dead;
  logic [HP_W-1:0] p_hp, ai_hp;

  hp_access_arbiter #(.HP_W(HP_W), .MAX_HP(MAX_HP)) dut (
    .clk(clk), .reset(reset), .load_hp(load_hp),
    .p_init_hp(p_init_hp), .ai_init_hp(ai_init_hp),
    .p_req(p_req), .p_op(p_op), .p_amt(p_amt),
    .ai_req(ai_req), .ai_op(ai_op), .ai_amt(ai_amt),
    .p_gnt(p_gnt), .ai_gnt(ai_gnt), .p_done(p_done), .ai_done(ai_done),
    .busy(busy), .p_hp(p_hp), .ai_hp(ai_hp), .p_dead(p_dead), .ai_dead(ai_dead)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted operation owns the datapath for three
  // cycles after its grant edge; its HP effect lands on the third edge.
  int m_p = 0, m_ai = 0, m_age = 0, m_amt = 0, m_cur = 0, m_new = 0;
  bit m_last_ai = 1'b1, m_own_ai = 1'b0, m_op = 1'b0, m_tgt_ai = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p = 0; m_ai = 0; m_age = 0; m_last_ai = 1'b1; m_own_ai = 1'b0;
    end else if (load_hp) begin
      m_p = int'(p_init_hp); m_ai = int'(ai_init_hp); m_age = 0;
    end else begin
      case (m_age)
        0: if (m_p != 0 && m_ai != 0 && (p_req || ai_req)) begin
             m_own_ai  = (p_req && ai_req) ? !m_last_ai : ai_req;
             m_last_ai = m_own_ai;
             m_op      = m_own_ai ? ai_op : p_op;
             m_amt     = m_own_ai ? int'(ai_amt) : int'(p_amt);
             m_tgt_ai  = m_own_ai ? m_op : !m_op;
             m_age     = 1;
           end
        1: m_age = 2;
        2: begin
             m_cur = m_tgt_ai ? m_ai : m_p;
             if (m_op) m_new = (m_cur + m_amt > MAX_HP) ? MAX_HP : m_cur + m_amt;
             else      m_new = (m_cur - m_amt < 0) ? 0 : m_cur - m_amt;
             if (m_tgt_ai) m_ai = m_new; else m_p = m_new;
             m_age = 3;
           end
        default: m_age = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("p_gnt",   32'(p_gnt),   32'(m_age != 0 && !m_own_ai));
    chk("ai_gnt",  32'(ai_gnt),  32'(m_age != 0 && m_own_ai));
    chk("p_done",  32'(p_done),  32'(m_age == 3 && !m_own_ai));
    chk("ai_done", 32'(ai_done), 32'(m_age == 3 && m_own_ai));
    chk("busy",    32'(busy),    32'(m_age != 0));
    chk("p_hp",    32'(p_hp),    32'(m_p));
    chk("ai_hp",   32'(ai_hp),   32'(m_ai));
    chk("p_dead",  32'(p_dead),  32'(m_p == 0));
    chk("ai_dead", 32'(ai_dead), 32'(m_ai == 0));
    chk("gnt_overlap", 32'(p_gnt & ai_gnt), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load(input int p, input int a);
    load_hp = 1'b1; p_init_hp = 8'(p); ai_init_hp = 8'(a);
    tick();
    load_hp = 1'b0;
  endtask

  // Raise one request, wait for its done (bounded), then drop it.
  task automatic run_op(input bit ai, input bit op, input int amt,
                        output int lat, output int gcnt);
    if (ai) begin ai_req = 1'b1; ai_op = op; ai_amt = 8'(amt); end
    else    begin p_req  = 1'b1; p_op  = op; p_amt  = 8'(amt); end
    lat = 0; gcnt = 0;
    forever begin
      tick();
      lat++;
      if (ai ? ai_gnt : p_gnt) gcnt++;
      if (ai ? ai_done : p_done) break;
      if (lat > 20) begin
        checks++; failures++;
        $display("FAIL run_op_timeout actual=no_done required=done");
        break;
      end
    end
    if (ai) ai_req = 1'b0; else p_req = 1'b0;
  endtask

  int lat, gcnt, seen, who, n;

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_p_hp", 32'(p_hp), 32'd0);
    chk("rst_p_dead", 32'(p_dead), 32'd1);
    chk("rst_ai_dead", 32'(ai_dead), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'({p_gnt, ai_gnt, p_done, ai_done}), 32'd0);
    tick();
    reset = 1'b0;

    // Player attack 15 on AI at 40
    do_load(50, 40);
    run_op(1'b0, 1'b0, 15, lat, gcnt);
    chk("atk_latency", 32'(lat), 32'd3);
    chk("atk_gnt_cycles", 32'(gcnt), 32'd3);
    chk("atk_ai_hp", 32'(ai_hp), 32'd25);
    chk("atk_p_hp", 32'(p_hp), 32'd50);
    tick();
    chk("atk_done_once", 32'(p_done), 32'd0);
    chk("atk_idle", 32'(busy), 32'd0);

    // AI attacks 30 twice: 50 -> 20 -> 0 (saturating), then player blocked
    run_op(1'b1, 1'b0, 30, lat, gcnt);
    chk("ai_atk_p_hp", 32'(p_hp), 32'd20);
    chk("ai_atk_ai_hp", 32'(ai_hp), 32'd25);
    tick();
    run_op(1'b1, 1'b0, 30, lat, gcnt);
    chk("sat_p_hp", 32'(p_hp), 32'd0);
    chk("sat_p_dead", 32'(p_dead), 32'd1);
    tick();
    p_req = 1'b1; seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (p_gnt) seen++; end
    chk("dead_blocks", 32'(seen), 32'd0);
    p_req = 1'b0;

    // Heal clamps
    do_load(95, 40);
    run_op(1'b0, 1'b1, 20, lat, gcnt);
    chk("heal_clamp", 32'(p_hp), 32'd100);
    tick();
    do_load(250, 40);
    run_op(1'b0, 1'b1, 10, lat, gcnt);
    chk("heal_over_max", 32'(p_hp), 32'd100);
    tick();
    run_op(1'b1, 1'b0, 0, lat, gcnt);
    chk("amt0_done", 32'(lat), 32'd3);
    chk("amt0_p_hp", 32'(p_hp), 32'd100);
    tick();

    // Both held: alternation P, AI, P, AI
    do_reset();
    do_load(100, 100);
    p_req = 1'b1; ai_req = 1'b1; p_op = 1'b0; ai_op = 1'b0; p_amt = 8'd1; ai_amt = 8'd1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(p_done || ai_done) && n < 20) begin tick(); n++; end
      who = ai_done ? 1 : 0;
      chk("rr_order", 32'(who), 32'(k % 2));
      if (who == 1) ai_req = 1'b0; else p_req = 1'b0;
      tick();
      if (who == 1) ai_req = 1'b1; else p_req = 1'b1;
    end
    p_req = 1'b0; ai_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rr_p_hp", 32'(p_hp), 32'd98);
    chk("rr_ai_hp", 32'(ai_hp), 32'd98);

    // load_hp during WRITE aborts, held request is re-granted
    do_load(60, 60);
    p_req = 1'b1; p_op = 1'b0; p_amt = 8'd10;
    tick(); tick();
    load_hp = 1'b1; p_init_hp = 8'd70; ai_init_hp = 8'd80;
    tick();
    load_hp = 1'b0;
    chk("ld_p_hp", 32'(p_hp), 32'd70);
    chk("ld_ai_hp", 32'(ai_hp), 32'd80);
    chk("ld_idle", 32'({busy, p_gnt, p_done}), 32'd0);
    tick();
    chk("ld_regrant", 32'(p_gnt), 32'd1);
    n = 0;
    while (!p_done && n < 10) begin tick(); n++; end
    p_req = 1'b0;
    chk("ld_after_ai_hp", 32'(ai_hp), 32'd70);
    tick();

    // Async reset in the middle of CALC
    do_load(60, 60);
    p_req = 1'b1;
    tick();
    #1 reset = 1'b1;
    #1;
    chk("arst_hp", 32'({p_hp, ai_hp}), 32'd0);
    chk("arst_dead", 32'({p_dead, ai_dead}), 32'd3);
    chk("arst_ctl", 32'({busy, p_gnt, p_done}), 32'd0);
    p_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("arst_no_done", 32'(p_done), 32'd0);

    // Randomized requesters with occasional loads
    do_load(120, 120);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        load_hp = 1'b1;
        p_init_hp  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        ai_init_hp = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end else begin
        load_hp = 1'b0;
      end
      if (!p_req) p_req = ($urandom_range(0, 3) == 0);
      else if (p_done) p_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 19) == 0) p_req = 1'b0;
      if (!ai_req) ai_req = ($urandom_range(0, 3) == 0);
      else if (ai_done) ai_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 19) == 0) ai_req = 1'b0;
      p_op   = 1'($urandom_range(0, 1));
      ai_op  = 1'($urandom_range(0, 1));
      p_amt  = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
      ai_amt = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
      tick();
    end
    load_hp = 1'b0; p_req = 1'b0; ai_req = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
